// File: rtl/output_parser_pkg.sv
// Shared types and elaboration helpers for the wide-chunk to FIFO-word output parser.
package output_parser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    TRAIL = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_TRAILER_TAG = 8'hA5;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Slice index width; clamped so an illegal RATIO still elaborates far enough to report.
  function automatic int calc_idx_w(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/output_parser_gen.sv
// Serialises IN_W-bit chunks into OUT_W-bit TX FIFO words with backpressure,
// frame word counting and an optional tagged trailer word per frame.
module output_parser_gen
  import output_parser_pkg::*;
#(
  parameter int         IN_W           = 128,
  parameter int         OUT_W          = 32,
  parameter bit         MSB_FIRST      = 1'b1,
  parameter bit         APPEND_TRAILER = 1'b1,
  parameter logic [7:0] TRAILER_TAG    = DEFAULT_TRAILER_TAG,
  parameter int         CNT_W          = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   data_flat,
  input  logic              data_ready,
  input  logic              data_idle,
  input  logic              fifo_full,
  output logic              parser_busy,
  output logic [OUT_W-1:0]  fifo_tx_din,
  output logic              fifo_tx_enable,
  output logic              frame_done,
  output logic [CNT_W-1:0]  word_count
);

  localparam int RATIO = calc_ratio(IN_W, OUT_W);
  localparam int IDX_W = calc_idx_w(RATIO);
  localparam int PAD_W = OUT_W - 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((IN_W % OUT_W) != 0 || RATIO < 2 || OUT_W < 16 || CNT_W < 1 || CNT_W > OUT_W - 8)
  begin : g_bad_params
    $fatal(1, "output_parser_gen: illegal IN_W/OUT_W/CNT_W combination");
  end

  state_t             state_reg;
  logic [IN_W-1:0]    shift_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               idle_reg;
  logic               busy_reg;
  logic [CNT_W-1:0]   word_count_reg;

  logic               last_slice;
  logic [OUT_W-1:0]   slice;
  logic [OUT_W-1:0]   trailer_word;

  assign last_slice   = (idx_reg == LAST_IDX);
  // The shift register always presents the next slice at the same end.
  assign slice        = MSB_FIRST ? shift_reg[IN_W-1 -: OUT_W] : shift_reg[OUT_W-1:0];
  assign trailer_word = {TRAILER_TAG, PAD_W'(word_count_reg)};

  // Write strobe depends only on registered state and fifo_full; reset blocks it at once.
  always_comb begin
    fifo_tx_enable = 1'b0;
    fifo_tx_din    = '0;
    frame_done     = 1'b0;
    if (!rst && !fifo_full) begin
      case (state_reg)
        SEND: begin
          fifo_tx_enable = 1'b1;
          fifo_tx_din    = slice;
          frame_done     = last_slice && idle_reg && !APPEND_TRAILER;
        end
        TRAIL: begin
          fifo_tx_enable = 1'b1;
          fifo_tx_din    = trailer_word;
          frame_done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      idx_reg        <= '0;
      idle_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      word_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (data_ready) begin
            shift_reg <= data_flat;
            idle_reg  <= data_idle;
            idx_reg   <= '0;
            state_reg <= SEND;
            busy_reg  <= 1'b1;
          end
        end
        SEND: begin
          if (fifo_tx_enable) begin
            shift_reg      <= MSB_FIRST ? (shift_reg << OUT_W) : (shift_reg >> OUT_W);
            idx_reg        <= idx_reg + IDX_W'(1);
            word_count_reg <= word_count_reg + CNT_W'(1);
            if (last_slice) begin
              if (!idle_reg) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end else if (APPEND_TRAILER) begin
                state_reg <= TRAIL;
              end else begin
                state_reg      <= IDLE;
                busy_reg       <= 1'b0;
                word_count_reg <= '0;
              end
            end
          end
        end
        TRAIL: begin
          if (fifo_tx_enable) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            word_count_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign parser_busy = busy_reg;
  assign word_count  = word_count_reg;

endmodule

// File: tb/tb_output_parser_gen.sv
// Directed bench: three parser builds (MSB-first, LSB-first, 4-bit counter) share one stimulus.
module tb_output_parser_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data_flat = '0;
  logic         data_ready = 1'b0;
  logic         data_idle = 1'b0;
  logic         fifo_full = 1'b0;

  logic        busy_a, en_a, done_a;
  logic [31:0] din_a;
  logic [23:0] cnt_a;
  logic        busy_b, en_b, done_b;
  logic [31:0] din_b;
  logic [23:0] cnt_b;
  logic        busy_c, en_c, done_c;
  logic [31:0] din_c;
  logic [3:0]  cnt_c;

  always #5 clk = ~clk;

  output_parser_gen #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b1), .APPEND_TRAILER(1'b1),
                      .TRAILER_TAG(8'hA5), .CNT_W(24)) dut_a (
    .clk(clk), .rst(rst), .data_flat(data_flat), .data_ready(data_ready),
    .data_idle(data_idle), .fifo_full(fifo_full), .parser_busy(busy_a),
    .fifo_tx_din(din_a), .fifo_tx_enable(en_a), .frame_done(done_a), .word_count(cnt_a));

  output_parser_gen #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b0), .APPEND_TRAILER(1'b1),
                      .TRAILER_TAG(8'hA5), .CNT_W(24)) dut_b (
    .clk(clk), .rst(rst), .data_flat(data_flat), .data_ready(data_ready),
    .data_idle(data_idle), .fifo_full(fifo_full), .parser_busy(busy_b),
    .fifo_tx_din(din_b), .fifo_tx_enable(en_b), .frame_done(done_b), .word_count(cnt_b));

  output_parser_gen #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b1), .APPEND_TRAILER(1'b1),
                      .TRAILER_TAG(8'hA5), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .data_flat(data_flat), .data_ready(data_ready),
    .data_idle(data_idle), .fifo_full(fifo_full), .parser_busy(busy_c),
    .fifo_tx_din(din_c), .fifo_tx_enable(en_c), .frame_done(done_c), .word_count(cnt_c));

  // Write monitor: logs every FIFO write and tracks protocol violations.
  logic [31:0] q_a[$], q_b[$], q_c[$], done_q_a[$], done_q_b[$], done_q_c[$];
  int busy_cycles = 0;
  int full_viol = 0;
  int din_viol = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (en_a) q_a.push_back(din_a);
      if (en_b) q_b.push_back(din_b);
      if (en_c) q_c.push_back(din_c);
      if (done_a) done_q_a.push_back(din_a);
      if (done_b) done_q_b.push_back(din_b);
      if (done_c) done_q_c.push_back(din_c);
      if (busy_a) busy_cycles++;
      if (fifo_full && (en_a || en_b || en_c)) full_viol++;
      if ((!en_a && din_a != 32'h0) || (!en_b && din_b != 32'h0) || (done_a && !en_a)) din_viol++;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Presents one chunk, optionally stalls the FIFO, and returns at the negedge busy is low.
  task automatic apply_chunk(input logic [127:0] d, input logic idle,
                             input int stall_at, input int stall_len);
    @(posedge clk); #1;
    data_flat  = d;
    data_ready = 1'b1;
    data_idle  = idle;
    @(posedge clk); #1;
    data_ready = 1'b0;
    data_idle  = 1'b0;
    data_flat  = '0;
    for (int c = 1; c <= 40; c++) begin
      fifo_full = (c > stall_at) && (c <= stall_at + stall_len);
      @(negedge clk);
      if (!busy_a) break;
      if (c == 40) check("busy_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
  endtask

  typedef struct {
    logic [127:0]      data;
    logic              idle;
    int                stall_at;
    int                stall_len;
    logic [0:3][31:0]  w;       // expected MSB-first write order
    logic [23:0]       cnt_a;
    logic [3:0]        cnt_c;
    logic [31:0]       trl_a;   // 0 means no trailer expected
    logic [31:0]       trl_c;
    int                busy;
  } vec_t;

  localparam logic [127:0] CHUNK_A = 128'hA1B2C3D4_E5F60718_192A3B4C_5D6E7F80;

  vec_t tbl[4];

  initial begin
    int ba, bb, bc, bda, bdb, bdc, bbusy, nw;
    logic [31:0] exp_w;

    tbl[0] = '{data: 128'h01234567_89ABCDEF_FEDCBA98_76543210, idle: 1'b0, stall_at: 0, stall_len: 0,
               w: {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210},
               cnt_a: 24'd8, cnt_c: 4'd8, trl_a: 32'h0, trl_c: 32'h0, busy: 4};
    tbl[1] = '{data: CHUNK_A, idle: 1'b0, stall_at: 2, stall_len: 3,
               w: {32'hA1B2C3D4, 32'hE5F60718, 32'h192A3B4C, 32'h5D6E7F80},
               cnt_a: 24'd12, cnt_c: 4'd12, trl_a: 32'h0, trl_c: 32'h0, busy: 7};
    tbl[2] = '{data: {128{1'b1}}, idle: 1'b0, stall_at: 0, stall_len: 0,
               w: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
               cnt_a: 24'd16, cnt_c: 4'd0, trl_a: 32'h0, trl_c: 32'h0, busy: 4};
    tbl[3] = '{data: 128'h00000001_80000000_DEADBEEF_CAFEF00D, idle: 1'b1, stall_at: 0, stall_len: 0,
               w: {32'h00000001, 32'h80000000, 32'hDEADBEEF, 32'hCAFEF00D},
               cnt_a: 24'd0, cnt_c: 4'd0, trl_a: 32'hA5000014, trl_c: 32'hA5000004, busy: 5};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_en", en_a, 1'b0);
    check("rst_din", din_a, 32'h0);
    check("rst_done", done_a, 1'b0);
    check("rst_cnt", cnt_a, 24'd0);
    check("rst_cnt_c", cnt_c, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First chunk, cycle by cycle: four consecutive writes in both slice orders
    @(posedge clk); #1;
    data_flat = CHUNK_A; data_ready = 1'b1; data_idle = 1'b0;
    bbusy = busy_cycles;
    @(posedge clk); #1;
    data_ready = 1'b0; data_flat = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      exp_w = CHUNK_A[127 - 32*j -: 32];
      check($sformatf("seq_en_%0d", j), en_a, 1'b1);
      check($sformatf("seq_msb_%0d", j), din_a, exp_w);
      exp_w = CHUNK_A[32*j +: 32];
      check($sformatf("seq_lsb_%0d", j), din_b, exp_w);
      check($sformatf("seq_busy_%0d", j), busy_a, 1'b1);
    end
    @(negedge clk);
    check("seq_busy_fall", busy_a, 1'b0);
    check("seq_en_off", en_a, 1'b0);
    check("seq_busy_len", busy_cycles - bbusy, 4);
    check("seq_cnt", cnt_a, 24'd4);

    // Table: continues the same frame, including a stall and the idle-marked close
    for (int v = 0; v < 4; v++) begin
      ba = q_a.size(); bb = q_b.size(); bc = q_c.size();
      bda = done_q_a.size(); bdb = done_q_b.size(); bdc = done_q_c.size();
      bbusy = busy_cycles;
      apply_chunk(tbl[v].data, tbl[v].idle, tbl[v].stall_at, tbl[v].stall_len);
      nw = (tbl[v].trl_a != 32'h0) ? 5 : 4;
      check($sformatf("v%0d_nwrites", v), q_a.size() - ba, nw);
      check($sformatf("v%0d_nwrites_b", v), q_b.size() - bb, nw);
      if (q_a.size() - ba == nw && q_b.size() - bb == nw) begin
        for (int j = 0; j < 4; j++) begin
          check($sformatf("v%0d_msb_%0d", v, j), q_a[ba + j], tbl[v].w[j]);
          check($sformatf("v%0d_lsb_%0d", v, j), q_b[bb + j], tbl[v].w[3 - j]);
        end
      end
      check($sformatf("v%0d_busy_len", v), busy_cycles - bbusy, tbl[v].busy);
      check($sformatf("v%0d_cnt_a", v), cnt_a, tbl[v].cnt_a);
      check($sformatf("v%0d_cnt_c", v), cnt_c, tbl[v].cnt_c);
      check($sformatf("v%0d_done_n", v), done_q_a.size() - bda, (nw == 5) ? 1 : 0);
      check($sformatf("v%0d_done_n_b", v), done_q_b.size() - bdb, (nw == 5) ? 1 : 0);
      if (nw == 5 && q_c.size() - bc == 5 && done_q_a.size() - bda == 1 && done_q_c.size() - bdc == 1) begin
        check($sformatf("v%0d_trailer_a", v), q_a[ba + 4], tbl[v].trl_a);
        check($sformatf("v%0d_done_word_a", v), done_q_a[bda], tbl[v].trl_a);
        check($sformatf("v%0d_trailer_c", v), q_c[bc + 4], tbl[v].trl_c);
        check($sformatf("v%0d_done_word_c", v), done_q_c[bdc], tbl[v].trl_c);
      end else if (nw == 5) begin
        check($sformatf("v%0d_trailer_present", v), 64'd0, 64'd1);
      end
    end

    // 16-chunk frame: 64 data words then trailer carrying 0x40
    ba = q_a.size(); bc = q_c.size(); bda = done_q_a.size();
    for (int i = 0; i < 16; i++) begin
      apply_chunk({8'(i), 8'd0, 16'h5A5A, 8'(i), 8'd1, 16'h5A5A,
                   8'(i), 8'd2, 16'h5A5A, 8'(i), 8'd3, 16'h5A5A}, i == 15, 0, 0);
    end
    check("f16_nwrites", q_a.size() - ba, 65);
    if (q_a.size() - ba == 65 && q_c.size() - bc == 65) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 4; j++) begin
          check($sformatf("f16_w%0d_%0d", i, j), q_a[ba + 4*i + j], {8'(i), 8'(j), 16'h5A5A});
        end
      end
      check("f16_trailer", q_a[ba + 64], 32'hA5000040);
      check("f16_trailer_c", q_c[bc + 64], 32'hA5000000);
    end
    check("f16_done_n", done_q_a.size() - bda, 1);
    if (done_q_a.size() - bda == 1) check("f16_done_word", done_q_a[bda], 32'hA5000040);
    check("f16_cnt", cnt_a, 24'd0);

    // Reset in the cycle of the second write
    @(posedge clk); #1;
    data_flat = CHUNK_A; data_ready = 1'b1; data_idle = 1'b0;
    @(posedge clk); #1;
    data_ready = 1'b0; data_flat = '0;
    ba = q_a.size();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_en", en_a, 1'b0);
    check("mrst_din", din_a, 32'h0);
    check("mrst_done", done_a, 1'b0);
    check("mrst_nwrites", q_a.size() - ba, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    data_idle = 1'b1;
    @(negedge clk);
    check("mrst_busy_after", busy_a, 1'b0);
    check("mrst_en_after", en_a, 1'b0);
    check("mrst_din_after", din_a, 32'h0);
    check("mrst_cnt_after", cnt_a, 24'd0);
    @(posedge clk); #1;
    data_idle = 1'b0;
    ba = q_a.size(); bda = done_q_a.size();
    apply_chunk(CHUNK_A, 1'b0, 0, 0);
    check("mrst_restart_n", q_a.size() - ba, 4);
    if (q_a.size() - ba == 4) check("mrst_restart_first", q_a[ba], 32'hA1B2C3D4);
    check("mrst_restart_cnt", cnt_a, 24'd4);
    check("mrst_no_trailer", done_q_a.size() - bda, 0);

    check("no_write_while_full", full_viol, 0);
    check("din_zero_when_idle", din_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
